// File: rtl/pending_request_encoder_32_pkg.sv
// Shared definitions for the 32-line pending request encoder:
// line count, index width, handshake FSM states and the one-hot helper
// used to build the clear mask from the presented index.
package pending_request_encoder_32_pkg;

  localparam int N_LINES = 32;
  localparam int IDX_W   = 5;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  // One-hot mask selecting line 'idx'.
  function automatic logic [N_LINES-1:0] onehot_of(input logic [IDX_W-1:0] idx);
    logic [N_LINES-1:0] mask;
    mask = '0;
    mask[idx] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/pending_request_encoder_32_if.sv
// Request/handshake bundle of the pending request encoder.
//
// Handshake: the encoder raises VALID with a stable IDX; the index is
// transferred on every rising edge where VALID=1 and ACK=1. ACK is ignored
// while VALID=0, and IDX never changes while VALID=1 and ACK=0.
// REQ bits are single-cycle pulses sampled on every rising edge.
// STATE is a debug view of the handshake FSM.
interface pending_request_encoder_32_if;
  import pending_request_encoder_32_pkg::*;

  logic [N_LINES-1:0] REQ;
  logic               ACK;
  logic [IDX_W-1:0]   IDX;
  logic               VALID;
  logic [N_LINES-1:0] PENDING;
  logic               OVERRUN;
  state_t             STATE;

  // Request source / index consumer side.
  modport master (
    output REQ,
    output ACK,
    input  IDX,
    input  VALID,
    input  PENDING,
    input  OVERRUN,
    input  STATE
  );

  // Encoder side.
  modport slave (
    input  REQ,
    input  ACK,
    output IDX,
    output VALID,
    output PENDING,
    output OVERRUN,
    output STATE
  );

endinterface

// File: rtl/pending_request_encoder_32_priority_scan_32.sv
// Combinational circular priority scan: finds the first set bit of 'vec'
// at or after position 'start', wrapping from 31 back to 0.
module priority_scan_32
  import pending_request_encoder_32_pkg::*;
(
  input  logic [N_LINES-1:0] vec,
  input  logic [IDX_W-1:0]   start,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] pos;

  // Walk the 32 positions starting at 'start'; the first hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int i = 0; i < N_LINES; i++) begin
      pos = start + IDX_W'(i);
      if (!found && vec[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/pending_request_encoder_32.sv
// Sequential 32-to-5 request encoder. Request pulses accumulate in a
// pending set; one pending line is presented as a binary index over a
// VALID/ACK handshake and its bit is cleared when acknowledged.
// Optional feature macro: PENC_ROUND_ROBIN_EN (round-robin selection
// starting after the last acknowledged index; default is lowest index).
module pending_request_encoder_32
  import pending_request_encoder_32_pkg::*;
(
  input  logic                           CLK,
  input  logic                           RESET,
  pending_request_encoder_32_if.slave    bus
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N_LINES-1:0] pending_q, pending_d;
  logic               overrun_q, overrun_d;
  logic [N_LINES-1:0] clr;
  logic               accept;
  logic               scan_found;
  logic [IDX_W-1:0]   scan_idx;
  logic [IDX_W-1:0]   scan_start;

  // Accepted transfer: only meaningful while presenting.
  always_comb begin
    accept = (state_q == PRESENT) && bus.ACK;
    clr    = accept ? onehot_of(idx_q) : '0;
  end

  // Pending set and sticky overrun; a new request beats a same-cycle clear.
  always_comb begin
    pending_d = (pending_q & ~clr) | bus.REQ;
    overrun_d = overrun_q | (|(bus.REQ & pending_q & ~clr));
  end

`ifdef PENC_ROUND_ROBIN_EN
  logic [IDX_W-1:0] last_q;

  // Remember the last acknowledged index; the scan resumes just after it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      last_q <= IDX_W'(N_LINES - 1);
    end else if (accept) begin
      last_q <= idx_q;
    end
  end

  assign scan_start = last_q + IDX_W'(1);
`else
  assign scan_start = '0;
`endif

  // The scan looks at the registered pending set, never at raw REQ.
  priority_scan_32 u_scan (
    .vec   (pending_q),
    .start (scan_start),
    .found (scan_found),
    .idx   (scan_idx)
  );

  // Handshake FSM next state and presented index.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (scan_found) begin
          state_d = PRESENT;
          idx_d   = scan_idx;
        end
      end
      PRESENT: begin
        // Hold the index until acknowledged; new requests do not preempt.
        if (bus.ACK) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset wins over every input, including REQ and ACK.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pending_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  // All outputs come straight from registers.
  assign bus.IDX     = idx_q;
  assign bus.VALID   = (state_q == PRESENT);
  assign bus.PENDING = pending_q;
  assign bus.OVERRUN = overrun_q;
  assign bus.STATE   = state_q;

endmodule

// File: doc/pending_request_encoder_32.md
# pending_request_encoder_32

Sequential 32-to-5 request encoder: the inverse path of the 5x32 line decoder. It collects single-cycle request pulses on 32 one-hot lines into a pending set and presents one selected pending line as a 5-bit binary index over a VALID/ACK handshake. The encoder clears the serviced bit on acknowledge. It sits between the register-file and datapath request sources and any consumer that needs a binary index, such as a decoder-driven write select or an interrupt/service sequencer.

## Interface
- No parameters; width is fixed at 32 lines / 5-bit index.
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  reset: synchronous, active-high.
- REQ  input  32  request pulses; bit i high at an edge sets pending bit i.
- ACK  input  1  consumer accepts the presented index; meaningful only while VALID=1.
- IDX  output  5  binary index of the presented request.
- VALID  output  1  IDX holds a pending request.
- PENDING  output  32  current pending set (registered).
- OVERRUN  output  1  sticky: a REQ bit arrived while the same bit was already pending.

## Operation
- Pending set:
  - PENDING_next = (PENDING & ~clr) | REQ.
  - clr is the one-hot of IDX when VALID&ACK, else 0.
  - Set wins over clear on the same bit in the same cycle, so the bit stays pending.
- OVERRUN sets when (REQ & PENDING & ~clr) != 0. It clears only on RESET.
- FSM, two states:
  - IDLE: VALID=0. If PENDING != 0 at an edge, latch the selected index into IDX and go to PRESENT. Otherwise stay.
  - PRESENT: VALID=1 and IDX held stable. On an edge with ACK=1: clear bit IDX, go to IDLE, VALID=0. With ACK=0: hold; new requests do not preempt.
- ACK while in IDLE is ignored.
- Selection (default): fixed priority, lowest set index wins.
- Selection scans the registered PENDING, not REQ.
- Reset values: PENDING=0, IDX=0, VALID=0, OVERRUN=0, state IDLE, LAST=31.
- RESET dominates every other input.
  - A REQ in the reset cycle is dropped.
  - Reset mid-handshake discards the presented index without a clear-then-reselect.

## Timing
- REQ bit sampled at edge N → PENDING bit visible after N → VALID=1 and IDX valid after edge N+1. Latency is 2 cycles.
- ACK sampled at edge M → VALID=0 and bit cleared after M. The next VALID comes no earlier than after edge M+1. This gives a one-cycle bubble; maximum throughput is one index per 2 cycles.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- PENC_ROUND_ROBIN_EN defined:
  - Register LAST (5 bits) is updated to IDX on each accepted ACK.
  - The selection scan starts at LAST+1 mod 32 and wraps 31→0.
  - After reset, LAST=31, so the first scan starts at 0.
- Not defined: fixed lowest-index priority. The LAST register is absent.

## Structure
- Shared package holds:
  - state enum {IDLE, PRESENT};
  - constants for line count (32) and index width (5);
  - the one-hot-of-index helper used for clr.
- One sub-module, priority_scan_32: combinational.
  - Inputs: vector and a 5-bit start position.
  - Outputs: found flag and 5-bit index of the first set bit at or after the start, wrapping.
  - The fixed-priority build ties start to 0.

## Test plan
- Reset, then REQ=32'h0000_0010 for one cycle → VALID=1, IDX=4 two edges later. ACK one cycle → VALID=0, PENDING=0.
- REQ=32'h8000_0003 in one cycle, ACK each presentation on arrival → fixed build presents IDX 0, 1, 31. VALID is low for exactly one cycle between presentations.
- While presenting IDX=5 with ACK=0, pulse REQ bit 2 → IDX stays 5 (no preemption). After ACK, IDX=2 is presented.
- ACK of IDX=7 in the same cycle as REQ bit 7 → bit 7 remains pending, IDX=7 is re-presented, OVERRUN stays 0. A REQ bit 7 while already pending and not acked → OVERRUN=1.
- With PENC_ROUND_ROBIN_EN, REQ bits 3 and 9 held pending, re-asserted after each ACK → presentations alternate 3, 9, 3, 9 rather than repeating 3.
- Assert RESET while VALID=1, with ACK=1 and REQ≠0 in that cycle → next cycle PENDING=0, VALID=0, IDX=0, OVERRUN=0.
